// File: rtl/c_bus_writeback.sv
// C-bus write-back unit: one-entry pending slot committing into PC/IR/MDR/R/AC, plus PC increment
// and memory loads into MDR. Define CBUS_BYPASS_EN to forward the pending entry to the outputs.
module c_bus_writeback #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] c_bus,
  input  logic         wr_valid,
  input  logic [2:0]   wr_dest,
  output logic         wr_ready,
  input  logic         pc_inc,
  input  logic [W-1:0] mem_data,
  input  logic         mem_load,
  output logic [W-1:0] PC,
  output logic [W-1:0] IR,
  output logic [W-1:0] MDR,
  output logic [W-1:0] R,
  output logic [W-1:0] AC,
  output logic         wr_err,
  output logic [7:0]   wb_count
);

  localparam logic [2:0] DestPc  = 3'b000;
  localparam logic [2:0] DestIr  = 3'b001;
  localparam logic [2:0] DestMdr = 3'b010;
  localparam logic [2:0] DestR   = 3'b011;
  localparam logic [2:0] DestAc  = 3'b100;

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  logic [0:0]   slot_q, slot_d;
  logic [W-1:0] pend_data_q, pend_data_d;
  logic [2:0]   pend_dest_q, pend_dest_d;
  logic [W-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, r_q, r_d, ac_q, ac_d;
  logic         err_q, err_d;
  logic [7:0]   cnt_q, cnt_d;

  logic stall, commit, legal, transfer;

  always_comb begin
    // A pending MDR write yields to a same-cycle memory load and waits in the slot.
    stall    = (slot_q == StFull) && (pend_dest_q == DestMdr) && mem_load;
    commit   = (slot_q == StFull) && !stall;
    legal    = (pend_dest_q <= DestAc);
    wr_ready = (slot_q == StEmpty) || commit;
    transfer = wr_valid && wr_ready;
  end

  always_comb begin
    slot_d      = slot_q;
    pend_data_d = pend_data_q;
    pend_dest_d = pend_dest_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    r_d         = r_q;
    ac_d        = ac_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    if (mem_load) begin
      mdr_d = mem_data;
    end
    if (pc_inc) begin
      pc_d = pc_q + W'(1);
    end

    if (commit) begin
      if (legal) begin
        cnt_d = cnt_q + 8'd1;
        case (pend_dest_q)
          DestPc:  pc_d  = pend_data_q;
          DestIr:  ir_d  = pend_data_q;
          DestMdr: mdr_d = pend_data_q;
          DestR:   r_d   = pend_data_q;
          DestAc:  ac_d  = pend_data_q;
          default: ;
        endcase
      end else begin
        err_d = 1'b1;
      end
      slot_d = StEmpty;
    end

    if (transfer) begin
      slot_d      = StFull;
      pend_data_d = c_bus;
      pend_dest_d = wr_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= StEmpty;
      pend_data_q <= '0;
      pend_dest_q <= '0;
      pc_q        <= '0;
      ir_q        <= '0;
      mdr_q       <= '0;
      r_q         <= '0;
      ac_q        <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      slot_q      <= slot_d;
      pend_data_q <= pend_data_d;
      pend_dest_q <= pend_dest_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      r_q         <= r_d;
      ac_q        <= ac_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef CBUS_BYPASS_EN
  always_comb begin
    PC  = pc_q;
    IR  = ir_q;
    MDR = mdr_q;
    R   = r_q;
    AC  = ac_q;
    if (slot_q == StFull) begin
      case (pend_dest_q)
        DestPc:  PC  = pend_data_q;
        DestIr:  IR  = pend_data_q;
        DestMdr: MDR = stall ? mem_data : pend_data_q;
        DestR:   R   = pend_data_q;
        DestAc:  AC  = pend_data_q;
        default: ;
      endcase
    end
  end
`else
  always_comb begin
    PC  = pc_q;
    IR  = ir_q;
    MDR = mdr_q;
    R   = r_q;
    AC  = ac_q;
  end
`endif

  assign wr_err   = err_q;
  assign wb_count = cnt_q;

endmodule

// File: tb/tb_c_bus_writeback.sv
// Randomised and directed bench for c_bus_writeback against a queue-based reference model.
module tb_c_bus_writeback;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] c_bus = '0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_dest = '0;
  logic       wr_ready;
  logic       pc_inc = 1'b0;
  logic [7:0] mem_data = '0;
  logic       mem_load = 1'b0;
  logic [7:0] PC, IR, MDR, R, AC;
  logic       wr_err;
  logic [7:0] wb_count;

  c_bus_writeback #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_bus    (c_bus),
    .wr_valid (wr_valid),
    .wr_dest  (wr_dest),
    .wr_ready (wr_ready),
    .pc_inc   (pc_inc),
    .mem_data (mem_data),
    .mem_load (mem_load),
    .PC       (PC),
    .IR       (IR),
    .MDR      (MDR),
    .R        (R),
    .AC       (AC),
    .wr_err   (wr_err),
    .wb_count (wb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] dest;
    logic [7:0] data;
  } wr_t;

  // Reference model: architectural registers indexed by destination code, pending writes in a queue.
  logic [7:0] m_reg [5];
  logic [7:0] m_cnt;
  logic       m_err;
  wr_t        m_pend [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    if (m_pend.size() == 0) return 1'b1;
    return !(m_pend[0].dest == 3'd2 && mem_load);
  endfunction

  // Value the DUT should present on output i right now.
  function automatic logic [7:0] model_view(input int i);
    logic [7:0] v;
    v = m_reg[i];
`ifdef CBUS_BYPASS_EN
    if (m_pend.size() != 0 && int'(m_pend[0].dest) == i) begin
      if (i == 2 && mem_load) v = mem_data;
      else v = m_pend[0].data;
    end
`endif
    return v;
  endfunction

  task automatic model_edge();
    logic ready, pc_written;
    wr_t  e;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      m_cnt = 8'h00;
      m_err = 1'b0;
      m_pend.delete();
      return;
    end
    ready      = model_ready();
    pc_written = 1'b0;
    if (mem_load) m_reg[2] = mem_data;
    if (m_pend.size() != 0 && ready) begin
      e = m_pend.pop_front();
      if (e.dest <= 3'd4) begin
        m_reg[e.dest] = e.data;
        m_cnt = m_cnt + 8'd1;
        if (e.dest == 3'd0) pc_written = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (pc_inc && !pc_written) m_reg[0] = m_reg[0] + 8'd1;
    if (wr_valid && ready) m_pend.push_back('{dest: wr_dest, data: c_bus});
  endtask

  task automatic check_outputs();
    check("PC", PC, model_view(0));
    check("IR", IR, model_view(1));
    check("MDR", MDR, model_view(2));
    check("R", R, model_view(3));
    check("AC", AC, model_view(4));
    check("wb_count", wb_count, m_cnt);
    check("wr_err", {7'd0, wr_err}, {7'd0, m_err});
  endtask

  // Called at a negedge: apply inputs, check wr_ready, advance one edge, check outputs at next negedge.
  task automatic step(input logic r, input logic v, input logic [2:0] d, input logic [7:0] cb,
                      input logic pi, input logic ml, input logic [7:0] md);
    rst = r; wr_valid = v; wr_dest = d; c_bus = cb; pc_inc = pi; mem_load = ml; mem_data = md;
    #1;
    if (!r) check("wr_ready", {7'd0, wr_ready}, {7'd0, model_ready()});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic put(input logic [2:0] d, input logic [7:0] cb);
    step(1'b0, 1'b1, d, cb, 1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] cnt_snap;
  logic       hold_v;
  logic [2:0] hold_d;
  logic [7:0] hold_cb;

  initial begin
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    m_cnt = 8'h00;
    m_err = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Preload nonzero registers, set wr_err, leave an entry pending, then reset.
    put(3'd0, 8'd12);
    put(3'd4, 8'd34);
    put(3'd1, 8'h21);
    put(3'd3, 8'h43);
    put(3'd2, 8'h65);
    put(3'd6, 8'h99);
    idle();
    check("pre_err", {7'd0, wr_err}, 8'h01);
    put(3'd3, 8'h55);
    step(1'b1, 1'b1, 3'd4, 8'hEE, 1'b1, 1'b1, 8'hCC);
    check("rst_ready", {7'd0, wr_ready}, 8'h01);
    check("rst_PC", PC, 8'h00);
    check("rst_err", {7'd0, wr_err}, 8'h00);
    idle();
    check("rst_pend_R", R, 8'h00);
    check("rst_cnt", wb_count, 8'h00);

    // Back-to-back writes.
    put(3'd3, 8'h5A);
    put(3'd4, 8'hA5);
    put(3'd1, 8'h3C);
    idle();
    check("b2b_R", R, 8'h5A);
    check("b2b_AC", AC, 8'hA5);
    check("b2b_IR", IR, 8'h3C);
    check("b2b_cnt", wb_count, 8'd3);

    // MDR conflict with a two-cycle memory load.
    put(3'd2, 8'h77);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 8'h11);
    check("stall_MDR", MDR, 8'h11);
    check("stall_ready", {7'd0, wr_ready}, 8'h00);
    idle();
    check("post_stall_MDR", MDR, 8'h77);

    // PC wrap and commit-over-increment priority.
    put(3'd0, 8'hFF);
    idle();
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("pc_wrap", PC, 8'h00);
    put(3'd0, 8'h40);
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("pc_prio", PC, 8'h40);

    // Illegal destination code.
    cnt_snap = wb_count;
    put(3'd6, 8'h99);
    idle();
    check("ill_err", {7'd0, wr_err}, 8'h01);
    check("ill_cnt", wb_count, cnt_snap);
    for (int i = 0; i < 10; i++) idle();
    check("ill_err_sticky", {7'd0, wr_err}, 8'h01);
    check("ill_R", R, 8'h5A);

    // Read-after-write visibility.
    put(3'd3, 8'h2B);
`ifdef CBUS_BYPASS_EN
    check("bypass_R_early", R, 8'h2B);
`else
    check("bypass_R_early", R, 8'h5A);
`endif
    idle();
    check("bypass_R_late", R, 8'h2B);

    // Random traffic; hold c_bus/wr_dest while a write is waiting on wr_ready.
    hold_v = 1'b0;
    hold_d = '0;
    hold_cb = '0;
    for (int n = 0; n < 400; n++) begin
      logic       r, v, pi, ml, rdy;
      logic [2:0] d;
      logic [7:0] cb, md;
      r  = ($urandom_range(0, 63) == 0);
      pi = ($urandom_range(0, 3) == 0);
      ml = ($urandom_range(0, 2) == 0);
      md = 8'($urandom);
      if (hold_v) begin
        v = 1'b1; d = hold_d; cb = hold_cb;
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        d  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        cb = 8'($urandom);
      end
      mem_load = ml;
      rdy = model_ready();
      hold_v = v && !rdy && !r;
      hold_d = d;
      hold_cb = cb;
      step(r, v, d, cb, pi, ml, md);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
